sipo_loader: RTL and testbench
==============================

// Module: sipo_loader
// PURPOSE
//   Serial-in/parallel-out word assembler: the upstream stage of the flopenr data register.
//   - Collects WIDTH qualified serial bits into one word.
//   - Presents the word on dout with a one-cycle load strobe; dout/load wire straight to flopenr d/en.
//   - Sits between a bit-serial source (pin sampler, test shifter) and the word-wide register bank.
// PARAMETERS
//   WIDTH      8   word width in bits; legal range 2..64
//   MSB_FIRST  1   1: first accepted bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//   clk        input   1          single clock; all state updates on posedge clk
//   reset      input   1          synchronous, active-high; dominates every other input
//   sin        input   1          serial data bit
//   sin_valid  input   1          sin is accepted on a posedge where sin_valid=1
//   clr        input   1          synchronous abort of the partial word
//   dout       output  WIDTH      last completed word; held between loads
//   load       output  1          one-cycle pulse: dout holds a new word this cycle
//   busy       output  1          1 while a partial word (1..WIDTH-1 bits) is held
//   bit_cnt    output  CW         bits accepted in the current word; CW=$clog2(WIDTH)
// BEHAVIOUR
//   - Reset (posedge, reset=1): dout=0, load=0, busy=0, bit_cnt=0, shift reg=0, FSM=IDLE.
//   - FSM states:
//     IDLE : bit_cnt=0, busy=0. sin_valid -> SHIFT, bit_cnt=1.
//     SHIFT: bit_cnt in 1..WIDTH-1, busy=1. Each sin_valid increments bit_cnt.
//       - Bit at bit_cnt==WIDTH-1 completes the word -> IDLE, bit_cnt=0.
//       - WIDTH==2 case: the bit at bit_cnt==1 completes the word.
//   - Shifting:
//     MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}
//     MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}
//   - Completion, on the edge accepting bit WIDTH:
//     - dout <= assembled word including that bit; load <= 1 for exactly the next cycle.
//     - Latency: last bit accepted at edge N -> load=1 and dout valid during cycle N..N+1.
//   - Back-to-back: a bit accepted on the completing edge+1 starts the next word.
//     Zero gap cycles required; load pulses may be WIDTH cycles apart.
//   - Gaps: sin_valid=0 holds sr, bit_cnt and FSM state indefinitely; load stays 0.
//   - clr=1 (reset=0):
//     - Effect: bit_cnt=0, FSM=IDLE, sr=0, load=0; dout is NOT modified.
//     - clr beats sin_valid on the same edge; the bit is dropped.
//     - A word completing on that same edge is discarded.
//   - Priority: reset > clr > sin_valid.
//   - Reset mid-word: partial bits lost, no load pulse, dout=0.
//   - load is never asserted on two consecutive cycles.
//   - dout changes only on edges that also raise load, or on reset.
// STRUCTURE
//   - Package sipo_pkg:
//     - typedef enum logic {IDLE, SHIFT} sipo_state_t
//     - function cnt_w(WIDTH) = $clog2(WIDTH)
//   - Sub-module: one existing flopenr #(WIDTH) instance for the dout register.
//     - d = next assembled word; en = word-complete; reset = (reset).
//     - Keeps dout hold semantics identical to the downstream register.
//   - FSM, bit counter, shift register and load flop are local always_ff logic.
// TESTING
//   1. Reset 2 cycles, release -> dout=8'h00, load=0, busy=0, bit_cnt=0.
//   2. MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles
//      -> load=1 for exactly one cycle after the 8th edge, dout=8'hA5, busy back to 0.
//   3. Same word with sin_valid=0 gaps of 3 cycles between bits
//      -> bit_cnt steps 1..7 and holds during gaps; single load; dout=8'hA5.
//   4. 3 bits of 8'hFF, then clr=1 with sin_valid=1, then full 8'h3C
//      -> dout stays 8'hA5 through clr; later load with dout=8'h3C only.
//   5. Back-to-back 8'hA5 then 8'h5A, no gap
//      -> two load pulses 8 cycles apart, dout=A5 then 5A.
//   6. MSB_FIRST=0, serial 8'h01 LSB first, reset asserted after 5 bits, then 8'hC3
//      -> no load for the aborted word, dout=0 after reset, then dout=8'hC3.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out word assembler.
package sipo_pkg;

    typedef enum logic {IDLE, SHIFT} sipo_state_t;

    // Width of the accepted-bit counter for a given word width.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/flopenr.sv
// Word register with synchronous active-high reset and load enable.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset clears the word, otherwise load d when enabled and hold when not.
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out word assembler feeding a flopenr register bank.
// Collects WIDTH accepted bits and presents the word with a one-cycle load strobe.
module sipo_loader
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     clr,
    output logic [WIDTH-1:0]         dout,
    output logic                     load,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sipo_state_t      state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             last_bit;
    logic             complete;

    // Shift register contents once the current bit is merged in.
    always_comb begin
        sr_nxt = sr;
        if (MSB_FIRST) sr_nxt = {sr[WIDTH-2:0], sin};
        else           sr_nxt = {sin, sr[WIDTH-1:1]};
    end

    // The word completes on the bit accepted while WIDTH-1 bits are already held;
    // clr wins over that bit, so an abort on the completing edge discards the word.
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
    assign complete = sin_valid && !clr && last_bit;

    // FSM, bit counter, shift register, busy flag and load strobe.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sr      <= '0;
            busy    <= 1'b0;
            load    <= 1'b0;
        end else begin
            load <= complete;
            if (sin_valid) begin
                sr <= sr_nxt;
                case (state)
                    IDLE: begin
                        state   <= SHIFT;
                        bit_cnt <= CW'(1);
                        busy    <= 1'b1;
                    end
                    SHIFT: begin
                        if (last_bit) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // dout uses the same register as the downstream bank, so hold behaviour matches.
    flopenr #(.WIDTH(WIDTH)) u_dout_reg (
        .clk   (clk),
        .reset (reset),
        .en    (complete),
        .d     (sr_nxt),
        .q     (dout)
    );

endmodule

// File: tb/tb_sipo_loader.sv
// Bench for sipo_loader: MSB-first and LSB-first instances share one serial stream,
// checked each cycle against a bit-list model plus directed literal expectations.
module tb_sipo_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       load_m, load_l;
    logic       busy_m, busy_l;
    logic [2:0] cnt_m, cnt_l;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sipo_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .dout(dout_m), .load(load_m), .busy(busy_m), .bit_cnt(cnt_m)
    );

    sipo_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .dout(dout_l), .load(load_l), .busy(busy_l), .bit_cnt(cnt_l)
    );

    // Model: list of accepted bits per instance; index 0 = MSB-first, 1 = LSB-first.
    logic       acc [2][8];
    int         cnt [2];
    logic [7:0] exp_dout [2];
    logic       exp_load [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                cnt[k] = 0; exp_dout[k] = 8'h00; exp_load[k] = 1'b0;
            end else if (clr) begin
                cnt[k] = 0; exp_load[k] = 1'b0;
            end else begin
                exp_load[k] = 1'b0;
                if (sin_valid) begin
                    acc[k][cnt[k]] = sin;
                    cnt[k] = cnt[k] + 1;
                    if (cnt[k] == 8) begin
                        for (int i = 0; i < 8; i++) begin
                            if (k == 0) exp_dout[k][7-i] = acc[k][i];
                            else        exp_dout[k][i]   = acc[k][i];
                        end
                        exp_load[k] = 1'b1;
                        cnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.dout",    64'(dout_m), 64'(exp_dout[0]));
            chk("m.load",    64'(load_m), 64'(exp_load[0]));
            chk("m.busy",    64'(busy_m), 64'(cnt[0] != 0));
            chk("m.bit_cnt", 64'(cnt_m),  64'(cnt[0]));
            chk("l.dout",    64'(dout_l), 64'(exp_dout[1]));
            chk("l.load",    64'(load_l), 64'(exp_load[1]));
            chk("l.busy",    64'(busy_l), 64'(cnt[1] != 0));
            chk("l.bit_cnt", 64'(cnt_l),  64'(cnt[1]));
        end
    end

    task automatic send_bit(input logic b);
        sin = b; sin_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [7:0] w, input bit lsb_first);
        for (int i = 0; i < 8; i++) send_bit(lsb_first ? w[i] : w[7-i]);
    endtask

    initial begin
        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("t1.dout", 64'(dout_m), 64'h00);
        chk("t1.load", 64'(load_m), 64'h0);
        chk("t1.busy", 64'(busy_m), 64'h0);
        chk("t1.cnt",  64'(cnt_m),  64'h0);
        idle(1);

        // 2. consecutive A5, MSB first
        send_word(8'hA5, 1'b0);
        chk("t2.load", 64'(load_m), 64'h1);
        chk("t2.dout", 64'(dout_m), 64'hA5);
        chk("t2.busy", 64'(busy_m), 64'h0);
        idle(1);
        chk("t2.load_drop", 64'(load_m), 64'h0);

        // 3. A5 with 3-cycle gaps
        for (int i = 0; i < 8; i++) begin
            send_bit(i == 0 || i == 2 || i == 5 || i == 7);
            if (i < 7) idle(3);
            if (i == 2) chk("t3.cnt_hold", 64'(cnt_m), 64'h3);
        end
        chk("t3.load", 64'(load_m), 64'h1);
        chk("t3.dout", 64'(dout_m), 64'hA5);
        idle(2);

        // 4. partial FF aborted by clr with a bit on the same edge, then 3C
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        clr = 1'b1; sin = 1'b1; sin_valid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; sin_valid = 1'b0;
        chk("t4.dout_kept", 64'(dout_m), 64'hA5);
        chk("t4.cnt",       64'(cnt_m),  64'h0);
        chk("t4.busy",      64'(busy_m), 64'h0);
        chk("t4.load",      64'(load_m), 64'h0);
        send_word(8'h3C, 1'b0);
        chk("t4.load3c", 64'(load_m), 64'h1);
        chk("t4.dout3c", 64'(dout_m), 64'h3C);
        idle(2);

        // 5. back-to-back A5 then 5A
        send_word(8'hA5, 1'b0);
        chk("t5.load1", 64'(load_m), 64'h1);
        chk("t5.dout1", 64'(dout_m), 64'hA5);
        send_word(8'h5A, 1'b0);
        chk("t5.load2", 64'(load_m), 64'h1);
        chk("t5.dout2", 64'(dout_m), 64'h5A);
        idle(2);

        // 6. LSB-first instance: 01 aborted by reset after 5 bits, then C3
        for (int i = 0; i < 5; i++) send_bit(i == 0);
        reset = 1'b1; sin_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6.dout_rst", 64'(dout_l), 64'h00);
        chk("t6.load_rst", 64'(load_l), 64'h0);
        chk("t6.cnt_rst",  64'(cnt_l),  64'h0);
        send_word(8'hC3, 1'b1);
        chk("t6.load", 64'(load_l), 64'h1);
        chk("t6.dout", 64'(dout_l), 64'hC3);
        idle(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
